velocity_tick_gen: RTL and testbench

Multi-channel, parametrised movement-rate generator for sprite motion (player and enemies). Per channel it selects a speed class from power-up, curse and energy inputs and emits a one-cycle `tick` pulse plus a toggling `velocity_clk` at `rate × PHASES`. Successor to the single-channel speed selector, with these additions:
- period changes apply only at tick boundaries, so the counter never wraps;
- optional linear ramping between speeds;
- per-channel resync.

It sits between the game-state logic and the movement-control FSMs, one channel per moving object.

---
 rtl/speed_pkg.sv | 34 +++
 rtl/velocity_tick_channel.sv | 97 +++++++++
 rtl/velocity_tick_gen.sv | 51 +++++
 tb/tb_velocity_tick_gen.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/speed_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | speed_pkg: speed classes, curse ratio and period helpers             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package speed_pkg;

  localparam longint unsigned HZ_FAST = 64'd22;
  localparam longint unsigned HZ_NORM = 64'd18;
  localparam longint unsigned HZ_SLOW = 64'd15;

  localparam longint unsigned CURSE_NUM = 64'd5;
  localparam longint unsigned CURSE_DEN = 64'd4;

  typedef enum logic [1:0] {
    FAST = 2'd0,
    NORM = 2'd1,
    SLOW = 2'd2
  } speed_class_e;

  function automatic longint unsigned calc_period(input longint unsigned clk_hz,
                                                  input longint unsigned hz,
                                                  input longint unsigned phases);
    return clk_hz / (hz * phases);
  endfunction

  // Multiply before dividing so the truncation happens once, at the end.
  function automatic longint unsigned cursed_period(input longint unsigned base);
    return (base * CURSE_NUM) / CURSE_DEN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/velocity_tick_channel.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | velocity_tick_channel: one channel's speed select, ramp and counter  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module velocity_tick_channel
  import speed_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int PHASES        = 3,
  parameter int ENERGY_W      = 11,
  parameter int LOW_ENERGY_TH = 3,
  parameter int RAMP_STEP     = 0,
  parameter int PER_W         = 32
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                en,
  input  logic                power_up_active,
  input  logic                curse_active,
  input  logic [ENERGY_W-1:0] energy,
  input  logic                resync,
  output logic                tick,
  output logic                velocity_clk
);

  localparam logic [PER_W-1:0] P_FAST  = PER_W'(calc_period(64'(CLK_HZ), HZ_FAST, 64'(PHASES)));
  localparam logic [PER_W-1:0] P_NORM  = PER_W'(calc_period(64'(CLK_HZ), HZ_NORM, 64'(PHASES)));
  localparam logic [PER_W-1:0] P_SLOW  = PER_W'(calc_period(64'(CLK_HZ), HZ_SLOW, 64'(PHASES)));
  localparam logic [PER_W-1:0] P_CNORM = PER_W'(cursed_period(calc_period(64'(CLK_HZ), HZ_NORM, 64'(PHASES))));
  localparam logic [PER_W-1:0] P_CSLOW = PER_W'(cursed_period(calc_period(64'(CLK_HZ), HZ_SLOW, 64'(PHASES))));
  localparam logic [PER_W-1:0] STEP    = PER_W'(RAMP_STEP);

  speed_class_e     speed_class;
  logic [PER_W-1:0] target;
  logic [PER_W-1:0] next_period;
  logic [PER_W-1:0] count;
  logic [PER_W-1:0] cur_period;

  always_comb begin
    speed_class = SLOW;
    if (power_up_active) begin
      speed_class = FAST;
    end else if (energy > ENERGY_W'(LOW_ENERGY_TH)) begin
      speed_class = NORM;
    end
  end

  // Curse only stretches the non-fast classes; power-up overrides it.
  always_comb begin
    target = P_SLOW;
    case (speed_class)
      FAST:    target = P_FAST;
      NORM:    target = curse_active ? P_CNORM : P_NORM;
      default: target = curse_active ? P_CSLOW : P_SLOW;
    endcase
  end

  always_comb begin
    next_period = target;
    if (RAMP_STEP != 0) begin
      if (cur_period < target) begin
        if ((target - cur_period) > STEP) next_period = cur_period + STEP;
      end else if (cur_period > target) begin
        if ((cur_period - target) > STEP) next_period = cur_period - STEP;
      end
    end
  end

  // The period only changes on a wrap, so count can never exceed it.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      cur_period   <= P_NORM;
      tick         <= 1'b0;
      velocity_clk <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (resync) begin
        count      <= '0;
        cur_period <= target;
      end else if (en) begin
        if (count == cur_period - 1'b1) begin
          count        <= '0;
          tick         <= 1'b1;
          velocity_clk <= ~velocity_clk;
          cur_period   <= next_period;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/velocity_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | velocity_tick_gen: N_CH independent movement-rate tick generators    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module velocity_tick_gen
  import speed_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CLK_HZ        = 100_000_000,
  parameter int PHASES        = 3,
  parameter int ENERGY_W      = 11,
  parameter int LOW_ENERGY_TH = 3,
  parameter int RAMP_STEP     = 0,
  parameter int PER_W         = 32
) (
  input  logic                       sysclk,
  input  logic                       reset,
  input  logic [N_CH-1:0]            en,
  input  logic [N_CH-1:0]            power_up_active,
  input  logic [N_CH-1:0]            curse_active,
  input  logic [N_CH*ENERGY_W-1:0]   energy,
  input  logic [N_CH-1:0]            resync,
  output logic [N_CH-1:0]            tick,
  output logic [N_CH-1:0]            velocity_clk
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    velocity_tick_channel #(
      .CLK_HZ        (CLK_HZ),
      .PHASES        (PHASES),
      .ENERGY_W      (ENERGY_W),
      .LOW_ENERGY_TH (LOW_ENERGY_TH),
      .RAMP_STEP     (RAMP_STEP),
      .PER_W         (PER_W)
    ) u_channel (
      .sysclk          (sysclk),
      .reset           (reset),
      .en              (en[i]),
      .power_up_active (power_up_active[i]),
      .curse_active    (curse_active[i]),
      .energy          (energy[i*ENERGY_W +: ENERGY_W]),
      .resync          (resync[i]),
      .tick            (tick[i]),
      .velocity_clk    (velocity_clk[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_velocity_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_velocity_tick_gen: directed checks of tick intervals and modes    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_velocity_tick_gen;

  localparam int N_CH   = 2;
  localparam int EW     = 11;
  localparam int LIMIT  = 200;

  logic            sysclk = 1'b0;
  logic            reset;
  logic [1:0]      en, pwr, curse, rsy;
  logic [2*EW-1:0] energy;
  logic [1:0]      tick, vclk;

  logic [1:0]      ramp_en, ramp_pwr, ramp_curse, ramp_rsy;
  logic [2*EW-1:0] ramp_energy;
  logic [1:0]      ramp_tick, ramp_vclk;

  int tests = 0;
  int fails = 0;

  always #5 sysclk = ~sysclk;

  velocity_tick_gen #(
    .N_CH(N_CH), .CLK_HZ(1980), .PHASES(3), .ENERGY_W(EW),
    .LOW_ENERGY_TH(3), .RAMP_STEP(0), .PER_W(32)
  ) dut (
    .sysclk(sysclk), .reset(reset), .en(en), .power_up_active(pwr),
    .curse_active(curse), .energy(energy), .resync(rsy),
    .tick(tick), .velocity_clk(vclk)
  );

  velocity_tick_gen #(
    .N_CH(N_CH), .CLK_HZ(1980), .PHASES(3), .ENERGY_W(EW),
    .LOW_ENERGY_TH(3), .RAMP_STEP(4), .PER_W(32)
  ) dut_ramp (
    .sysclk(sysclk), .reset(reset), .en(ramp_en), .power_up_active(ramp_pwr),
    .curse_active(ramp_curse), .energy(ramp_energy), .resync(ramp_rsy),
    .tick(ramp_tick), .velocity_clk(ramp_vclk)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Counts falling edges until the selected tick is seen; -1 on timeout.
  task automatic wait_tick(input bit use_ramp, input int ch, output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int k = 1; k <= LIMIT && !found; k++) begin
      @(negedge sysclk);
      if (use_ramp ? ramp_tick[ch] : tick[ch]) begin
        n = k;
        found = 1'b1;
      end
    end
  endtask

  task automatic do_resync(input logic [1:0] mask);
    rsy = mask;
    @(negedge sysclk);
    rsy = 2'b00;
  endtask

  initial begin
    int n;
    int seen;

    reset = 1'b1; en = 2'b00; pwr = 2'b00; curse = 2'b00; rsy = 2'b00;
    energy = '0; energy[0 +: EW] = 11'd10; energy[EW +: EW] = 11'd10;
    ramp_en = 2'b00; ramp_pwr = 2'b00; ramp_curse = 2'b00; ramp_rsy = 2'b00;
    ramp_energy = '0; ramp_energy[0 +: EW] = 11'd10; ramp_energy[EW +: EW] = 11'd10;
    repeat (2) @(negedge sysclk);
    check("reset_tick", int'(tick), 0);
    check("reset_vclk", int'(vclk), 0);

    // Normal speed on both channels
    reset = 1'b0; en = 2'b11;
    wait_tick(0, 0, n);
    check("first_tick", n, 36);
    check("ch1_first_tick", int'(tick[1]), 1);
    check("vclk_after_1", int'(vclk), 3);
    wait_tick(0, 0, n);
    check("norm_interval", n, 36);
    check("vclk_after_2", int'(vclk), 0);

    // Power-up mid-interval only affects ch0's later intervals
    repeat (10) @(negedge sysclk);
    pwr = 2'b01;
    wait_tick(0, 0, n);
    check("pwr_cur_interval", n + 10, 36);
    check("ch1_with_ch0", int'(tick[1]), 1);
    wait_tick(0, 0, n);
    check("pwr_interval", n, 30);
    check("ch1_not_fast", int'(tick[1]), 0);
    wait_tick(0, 1, n);
    check("ch1_remaining", n, 6);

    // Curse handling
    pwr = 2'b00; curse = 2'b01; energy[0 +: EW] = 11'd3;
    do_resync(2'b11);
    wait_tick(0, 0, n);
    check("cursed_slow", n, 55);
    pwr = 2'b01;
    do_resync(2'b01);
    wait_tick(0, 0, n);
    check("curse_pwr_resync", n, 30);
    wait_tick(0, 0, n);
    check("curse_pwr_interval", n, 30);
    pwr = 2'b00; energy[0 +: EW] = 11'd10;
    do_resync(2'b01);
    wait_tick(0, 0, n);
    check("cursed_norm", n, 45);

    // Enable gating and resync
    curse = 2'b00;
    do_resync(2'b11);
    wait_tick(0, 0, n);
    check("resync_norm", n, 36);
    repeat (10) @(negedge sysclk);
    en = 2'b00;
    seen = 0;
    repeat (10) begin
      @(negedge sysclk);
      if (tick != 2'b00) seen++;
    end
    check("no_tick_disabled", seen, 0);
    en = 2'b11;
    wait_tick(0, 0, n);
    check("en_gap_interval", n + 20, 46);
    repeat (15) @(negedge sysclk);
    do_resync(2'b01);
    wait_tick(0, 0, n);
    check("resync_mid", n, 36);

    // Asynchronous reset between edges
    if (vclk[0] == 1'b0) wait_tick(0, 0, n);
    repeat (20) @(negedge sysclk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_vclk", int'(vclk), 0);
    check("async_rst_tick", int'(tick), 0);
    @(negedge sysclk);
    reset = 1'b0;
    wait_tick(0, 0, n);
    check("post_reset_first", n, 36);

    // Ramped speed changes on the second instance
    ramp_energy[0 +: EW] = 11'd3;
    ramp_en = 2'b01;
    wait_tick(1, 0, n);
    check("ramp_i1", n, 36);
    wait_tick(1, 0, n);
    check("ramp_i2", n, 40);
    wait_tick(1, 0, n);
    check("ramp_i3", n, 44);
    wait_tick(1, 0, n);
    check("ramp_i4", n, 44);
    ramp_energy[0 +: EW] = 11'd10;
    wait_tick(1, 0, n);
    check("ramp_d1", n, 44);
    wait_tick(1, 0, n);
    check("ramp_d2", n, 40);
    wait_tick(1, 0, n);
    check("ramp_d3", n, 36);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
